// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, FSM state type and parity helper
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int FRAME_BITS = 11;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous power-of-two FIFO with occupancy count
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rd_data = mem[rd_ptr];
    // pointers wrap naturally at DEPTH; count tracks simultaneous push/pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // storage needs no reset; occupancy is governed by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: buffered 8E1 serial transmitter with registered tx line
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    tx_state_t state, state_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [BW-1:0] bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next, head;
    logic par, par_next, tx_next, bit_end, pop, full, empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(in_valid),
        .wr_data(in_data),
        .pop(pop),
        .rd_data(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );
    assign bit_end = clk_cnt == CLK_LAST;
    // state and datapath registers; tx is loaded with the level of the upcoming cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            par <= 1'b0;
            tx <= IDLE_LEVEL;
        end else begin
            state <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_cnt <= bit_cnt_next;
            shreg <= shreg_next;
            par <= par_next;
            tx <= tx_next;
        end
    end
    // next state plus counter/shift updates; a pop reloads the shifter from the FIFO head
    always_comb begin
        case (state)
            IDLE:    state_next = empty ? IDLE : START;
            START:   state_next = bit_end ? DATA : START;
            DATA:    state_next = (bit_end && bit_cnt == BIT_LAST) ? PARITY : DATA;
            PARITY:  state_next = bit_end ? STOP : PARITY;
            STOP:    state_next = bit_end ? (empty ? IDLE : START) : STOP;
            default: state_next = IDLE;
        endcase
        pop = !empty && (state == IDLE || (state == STOP && bit_end));
        clk_cnt_next = (state == IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
        bit_cnt_next = state != DATA ? '0 : bit_end ? bit_cnt + 1'b1 : bit_cnt;
        shreg_next = pop ? head : (state == DATA && bit_end) ? shreg >> 1 : shreg;
        par_next = pop ? even_parity(head) : par;
    end
    // outputs: tx level for the next state, stop-end pulse, status flags
    always_comb begin
        tx_next = state_next == START  ? START_LEVEL :
                  state_next == DATA   ? shreg_next[0] :
                  state_next == PARITY ? par_next :
                  state_next == STOP   ? STOP_LEVEL : IDLE_LEVEL;
        tx_done = state == STOP && bit_end;
        busy = state != IDLE || fifo_count != '0;
        in_ready = !full;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed self-checking bench for uart_transmitter
module tb_uart_transmitter;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] in_data1, in_data4;
    logic in_valid1, in_valid4;
    logic in_ready1, tx1, busy1, tx_done1;
    logic in_ready4, tx4, busy4, tx_done4;
    int total = 0;
    int fails = 0;
    logic [7:0] pend[$];
    logic [7:0] burst[5] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55};
    logic [7:0] stream[10] = '{8'h11, 8'h2E, 8'h53, 8'h7C, 8'h90, 8'hA1, 8'hC6, 8'hDF, 8'hE8, 8'hF7};
    logic [7:0] rx_d;
    logic rx_p, rx_sent;
    logic [10:0] lead;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) d1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx(tx1), .busy(busy1), .tx_done(tx_done1)
    );
    uart_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) d4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .tx(tx4), .busy(busy4), .tx_done(tx_done4)
    );

    function automatic logic [10:0] frame(input logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input logic [10:0] f, input bit four, input logic [10:0] mask, input string tag);
        int done_n = 0;
        int cpb = four ? 4 : 1;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < cpb; c++) begin
                if (!four && c == 0 && mask[i] && pend.size() > 0) begin
                    in_valid1 = 1'b1;
                    in_data1 = pend.pop_front();
                end
                step();
                in_valid1 = 1'b0;
                chk($sformatf("%s_bit%0d", tag, i), four ? tx4 : tx1, f[i]);
                done_n += int'(four ? tx_done4 : tx_done1);
            end
        end
        chk({tag, "_done_pulses"}, done_n, 1);
    endtask

    task automatic rx_frame(output logic [7:0] d, output logic p, output logic sent);
        logic [10:0] bits;
        for (int i = 0; i < 11; i++) begin
            step();
            bits[i] = tx1;
        end
        d = bits[8:1];
        p = bits[9];
        sent = bits[0] == 1'b0 && bits[10] == 1'b1 && p == ^d;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid1 = 1'b1;
        in_data1 = 8'h5A;
        in_valid4 = 1'b0;
        in_data4 = 8'h00;
        step();
        step();
        chk("rst_tx", tx1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_ready", in_ready1, 1);
        chk("rst_done", tx_done1, 0);
        chk("rst_tx4", tx4, 1);
        chk("rst_busy4", busy4, 0);
        in_valid1 = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rst_ignored_busy", busy1, 0);
        chk("rst_ignored_tx", tx1, 1);

        in_data1 = 8'hA5;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        chk("a5_busy", busy1, 1);
        chk("a5_accept_tx", tx1, 1);
        check_frame(11'b10101001010, 1'b0, 11'b0, "a5");
        step();
        chk("a5_end_tx", tx1, 1);
        chk("a5_end_busy", busy1, 0);

        in_data1 = 8'h01;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        rx_frame(rx_d, rx_p, rx_sent);
        chk("rx_data", rx_d, 8'h01);
        chk("rx_parity", rx_p, 1);
        chk("rx_sent", rx_sent, 1);
        step();

        lead = frame(8'hC3);
        in_data1 = 8'hC3;
        in_valid1 = 1'b1;
        step();
        for (int i = 0; i < 11; i++) begin
            in_valid1 = i < 5;
            in_data1 = i < 5 ? burst[i] : 8'h00;
            step();
            chk($sformatf("lead_bit%0d", i), tx1, lead[i]);
            if (i == 2) chk("burst_ready_open", in_ready1, 1);
            if (i == 3) chk("burst_ready_full", in_ready1, 0);
        end
        in_valid1 = 1'b0;
        for (int k = 0; k < 4; k++) check_frame(frame(burst[k]), 1'b0, 11'b0, $sformatf("burst%0d", k));
        step();
        chk("burst_end_tx", tx1, 1);
        chk("burst_end_busy", busy1, 0);

        for (int k = 1; k < 10; k++) pend.push_back(stream[k]);
        in_data1 = stream[0];
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check_frame(frame(stream[0]), 1'b0, 11'b11, "s0");
        chk("s0_count", d1.u_fifo.count, 2);
        for (int k = 1; k < 10; k++) begin
            check_frame(frame(stream[k]), 1'b0, k <= 7 ? 11'b1 : 11'b0, $sformatf("s%0d", k));
            chk($sformatf("s%0d_count", k), d1.u_fifo.count, k <= 7 ? 2 : 9 - k);
        end
        step();
        chk("stream_end_tx", tx1, 1);
        chk("stream_end_busy", busy1, 0);

        in_data1 = 8'h00;
        in_valid1 = 1'b1;
        step();
        in_data1 = 8'hE7;
        step();
        in_data1 = 8'h3D;
        step();
        in_valid1 = 1'b0;
        step();
        step();
        chk("abort_pre_tx", tx1, 0);
        chk("abort_pre_busy", busy1, 1);
        rst_n = 1'b0;
        step();
        chk("abort_tx", tx1, 1);
        chk("abort_busy", busy1, 0);
        chk("abort_ready", in_ready1, 1);
        chk("abort_done", tx_done1, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("abort_idle_tx%0d", i), tx1, 1);
            chk($sformatf("abort_idle_busy%0d", i), busy1, 0);
        end

        in_data4 = 8'h80;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        chk("c4_accept_tx", tx4, 1);
        check_frame(11'b11100000000, 1'b1, 11'b0, "c4");
        step();
        chk("c4_end_tx", tx4, 1);
        chk("c4_end_busy", busy4, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1, giving clocks per serial bit (>=1); the value 1 matches the receiver's one-bit-per-clk sampling.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the transmit buffer depth in words (power of two, >=2).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_data, input, 8 bits: byte to transmit.
REQ-006 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 Port in_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-008 Port tx, output, 1 bit: serial line, idle high, driven to the receiver's rx.
REQ-009 Port busy, output, 1 bit: a frame is on the line or the FIFO holds data.
REQ-010 Port tx_done, output, 1 bit: one-cycle pulse on the final cycle of each stop bit.

Function
REQ-011 Frame SHALL be 11 bits in order: start (0), data[0]..data[7] (LSB first), even parity (XOR of the 8 data bits), stop (1).
REQ-012 Each frame bit SHALL be held on tx for exactly CLKS_PER_BIT cycles; a frame lasts 11*CLKS_PER_BIT cycles.
REQ-013 A byte SHALL be written into the FIFO on a rising edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored (byte dropped, no error).
REQ-014 in_ready SHALL equal NOT full; a write while full is refused even if a pop occurs in the same cycle.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: tx=1; on an edge with the FIFO non-empty, pop the head byte, latch it and its parity, enter START.
REQ-017 START->DATA, DATA (8 bits, counter 0..7)->PARITY, and PARITY->STOP SHALL each advance when the bit-period counter reaches CLKS_PER_BIT-1.
REQ-018 At the end of STOP, the FSM SHALL pop the next byte and enter START directly if the FIFO is non-empty (zero-gap back-to-back), otherwise enter IDLE.
REQ-019 tx SHALL be a registered output; with IDLE and an empty FIFO, the start bit SHALL appear on tx starting at the first edge after the accepting edge (1-cycle latency).
REQ-020 A write and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-021 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from a count of width clog2(FIFO_DEPTH)+1.
REQ-022 busy SHALL be 1 whenever the state is not IDLE or the FIFO is non-empty.

Reset
REQ-023 On a rising edge with rst_n=0: state=IDLE, FIFO emptied, counters cleared, tx=1, tx_done=0; busy=0 and in_ready=1 thereafter.
REQ-024 Reset asserted mid-frame SHALL abort the frame and raise tx at that edge; the aborted byte and all buffered bytes are discarded.
REQ-025 in_valid during reset SHALL be ignored.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enum, DATA_BITS=8, FRAME_BITS=11, and the start, stop, and idle line-level constants, for reuse by the receiver.
REQ-027 The FIFO SHALL be sub-module uart_tx_fifo (sync, parameterised depth/width, push/pop/full/empty/count), instantiated once.
REQ-028 The FSM, bit counter, bit-period counter, and shift register SHALL live in uart_transmitter.

Verification
REQ-029 With CLKS_PER_BIT=1, write 0xA5 -> tx from the next edge: 0,1,0,1,0,0,1,0,1,0,1, then idle 1; tx_done pulses once; busy falls after stop.
REQ-030 With CLKS_PER_BIT=1, tx looped to the receiver's rx, write 0x01 (parity 1) -> receiver reports data=0x01, sent=1.
REQ-031 With in_valid held, write 0x00,0xFF,0x3C,0x81,0x55 in consecutive cycles -> in_ready drops when the FIFO fills, the refused byte is absent, and accepted bytes appear as gapless frames in order.
REQ-032 With CLKS_PER_BIT=4, write 0x80 -> each bit is held 4 cycles, the frame spans 44 cycles, and parity=1.
REQ-033 Assert rst_n=0 during DATA bit 3 with 2 bytes queued -> tx=1 at the reset edge, busy=0, and no further frames until a new write.
REQ-034 Write and pop in the same cycle at count=2 -> count remains 2 and the pointers wrap correctly over 10 bytes streamed.
